// File: rtl/postbox_usb_pkg.sv
// Shared constants and FSM state type for the POST box bridge.
// Pulse numbers count from 1 within a testreq pulse group.
package postbox_usb_pkg;

   localparam int unsigned BREAK_CYCLES = 480;

   localparam logic [7:0] PULSE_OUT_READY = 8'd3;
   localparam logic [7:0] PULSE_IN_READY  = 8'd4;
   localparam logic [7:0] PULSE_IN_LAST   = 8'd12;
   localparam logic [7:0] CHAIN_PULSES    = 8'd9;

   // A chained input link is one ready-check pulse followed by the data bits.
   localparam logic [3:0] BYTE_BITS = 4'(CHAIN_PULSES - 8'd1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_INPUT_SHIFT,
      ST_OUTPUT_BITS
   } state_t;

endpackage

// File: rtl/postbox_usb_if.sv
// Target-connector and SPI pins of the POST box, grouped for the FPGA top.
// The slave side is the bridge; the master side is the target plus host MCU.
interface postbox_usb_if;
   logic fpga_spi_cs;
   logic fpga_spi_sck;
   logic fpga_spi_mosi;
   logic fpga_spi_miso;
   logic testreq_3v;
   logic testack_noe;
   logic target_reset_noe;
   logic target_power_3v;
   logic target_power_out;
   logic hotswap_noe;

   modport slave (
      input  fpga_spi_cs, fpga_spi_sck, fpga_spi_mosi, testreq_3v, target_power_3v,
      output fpga_spi_miso, testack_noe, target_reset_noe, target_power_out, hotswap_noe
   );

   modport master (
      output fpga_spi_cs, fpga_spi_sck, fpga_spi_mosi, testreq_3v, target_power_3v,
      input  fpga_spi_miso, testack_noe, target_reset_noe, target_power_out, hotswap_noe
   );
endinterface

// File: rtl/postbox_spi_slave.sv
// Mode-0 SPI slave for exactly 16-bit frames: status/flags byte, then data byte.
// Emits one-cycle load/clear strobes at chip-select rise of a complete frame.
module postbox_spi_slave (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       sck,
   input  logic       mosi,
   input  logic       tx_empty,
   input  logic       rx_full,
   input  logic [7:0] rx_data,
   output logic       miso,
   output logic       load_tx,
   output logic [7:0] load_data,
   output logic       clear_rx
);

   logic [2:0] cs_q;
   logic [2:0] sck_q;
   logic [1:0] mosi_q;
   logic [4:0] bit_cnt;
   logic [7:0] shift_in;
   logic [7:0] shift_out;
   logic [1:0] cmd;
   logic       lat_tx_empty;
   logic       lat_rx_full;

   logic active, cs_fall, cs_rise, sck_rise, sck_fall;

   assign active   = ~cs_q[1];
   assign cs_fall  = ~cs_q[1] &  cs_q[2];
   assign cs_rise  =  cs_q[1] & ~cs_q[2];
   assign sck_rise =  sck_q[1] & ~sck_q[2];
   assign sck_fall = ~sck_q[1] &  sck_q[2];
   assign miso     = active & shift_out[7];

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_q         <= 3'b111;
         sck_q        <= 3'b000;
         mosi_q       <= 2'b00;
         bit_cnt      <= 5'd0;
         shift_in     <= 8'h00;
         shift_out    <= 8'h00;
         cmd          <= 2'b00;
         lat_tx_empty <= 1'b0;
         lat_rx_full  <= 1'b0;
         load_tx      <= 1'b0;
         load_data    <= 8'h00;
         clear_rx     <= 1'b0;
      end else begin
         // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
         cs_q     <= {cs_q[1:0], cs};
         sck_q    <= {sck_q[1:0], sck};
         mosi_q   <= {mosi_q[0], mosi};
         load_tx  <= 1'b0;
         clear_rx <= 1'b0;

         if (cs_fall) begin
            bit_cnt      <= 5'd0;
            lat_tx_empty <= tx_empty;
            lat_rx_full  <= rx_full;
            shift_out    <= {6'b0, tx_empty, rx_full};
         end else if (active) begin
            if (sck_rise) begin
               shift_in <= {shift_in[6:0], mosi_q[1]};
               if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
               if (bit_cnt == 5'd7) cmd <= {shift_in[0], mosi_q[1]};
            end
            // The data byte replaces the status byte on the falling edge after bit 8.
            if (sck_fall) begin
               if (bit_cnt == 5'd8) shift_out <= lat_rx_full ? rx_data : 8'h00;
               else                 shift_out <= {shift_out[6:0], 1'b0};
            end
         end

         if (cs_rise && bit_cnt == 5'd16) begin
            load_tx   <= cmd[1] & lat_tx_empty;
            load_data <= shift_in;
            clear_rx  <= cmd[0] & lat_rx_full;
         end
      end
   end

endmodule

// File: rtl/postbox_usb.sv
// POST test-port bridge: decodes testreq pulse groups from the target and
// exchanges one byte each way with the host MCU over SPI.
module postbox_usb
   import postbox_usb_pkg::*;
(
   input  logic         fpga_clock_48mhz,
   input  logic         reset_in,
   postbox_usb_if.slave bus
);

   localparam logic [8:0] BREAK_COUNT = 9'(BREAK_CYCLES);

   logic [2:0] req_q;
   logic [1:0] power_q;
   logic [8:0] low_cnt;
   logic [7:0] pulse_cnt;
   logic [7:0] pulse_n;
   state_t     state;
   logic [3:0] bits_left;
   logic [7:0] in_shift;
   logic       cmd_ok;
   logic [2:0] out_idx;
   logic [6:0] out_shift;
   logic       ack, ack_next, hotswap_noe_q;
   logic       tx_full, rx_full;
   logic [7:0] tx_data, rx_data;
   logic       spi_load_tx, spi_clear_rx;
   logic [7:0] spi_data;
   logic       req_rise, group_end, check_pulse, group_bit;

   postbox_spi_slave u_spi (
      .clk       (fpga_clock_48mhz),
      .rst       (reset_in),
      .cs        (bus.fpga_spi_cs),
      .sck       (bus.fpga_spi_sck),
      .mosi      (bus.fpga_spi_mosi),
      .tx_empty  (~tx_full),
      .rx_full   (rx_full),
      .rx_data   (rx_data),
      .miso      (bus.fpga_spi_miso),
      .load_tx   (spi_load_tx),
      .load_data (spi_data),
      .clear_rx  (spi_clear_rx)
   );

   assign req_rise    = req_q[1] & ~req_q[2];
   assign group_end   = ~req_q[1] && (low_cnt == BREAK_COUNT - 9'd1);
   assign pulse_n     = pulse_cnt + 8'd1;
   assign group_bit   = (pulse_cnt == 8'd2);
   // Ready checks: pulse 4, or the first pulse after each byte of a chained read.
   assign check_pulse = (bits_left == 4'd0) &&
                        ((pulse_n == PULSE_IN_READY) ||
                         (state == ST_INPUT_SHIFT && pulse_n > PULSE_IN_LAST));

   always_comb begin
      // NOTE: default first so no path through the block leaves ack_next unassigned (no latch).
      ack_next = 1'b0;
      if (state == ST_OUTPUT_BITS)          ack_next = 1'b0;
      else if (bits_left != 4'd0)           ack_next = in_shift[7];
      else if (pulse_n == PULSE_OUT_READY)  ack_next = ~rx_full;
      else if (check_pulse)                 ack_next = tx_full;
   end

   assign bus.testack_noe      = ~ack;
   assign bus.target_reset_noe = 1'b1;
   assign bus.target_power_out = power_q[1];
   assign bus.hotswap_noe      = hotswap_noe_q;

   always_ff @(posedge fpga_clock_48mhz) begin
      if (reset_in) begin
         req_q         <= 3'b000;
         power_q       <= 2'b00;
         low_cnt       <= 9'd0;
         pulse_cnt     <= 8'd0;
         state         <= ST_IDLE;
         bits_left     <= 4'd0;
         in_shift      <= 8'h00;
         cmd_ok        <= 1'b0;
         out_idx       <= 3'd0;
         out_shift     <= 7'd0;
         ack           <= 1'b0;
         hotswap_noe_q <= 1'b1;
         tx_full       <= 1'b0;
         tx_data       <= 8'h00;
         rx_full       <= 1'b0;
         rx_data       <= 8'h00;
      end else begin
         req_q         <= {req_q[1:0], bus.testreq_3v};
         power_q       <= {power_q[0], bus.target_power_3v};
         hotswap_noe_q <= 1'b0;

         if (req_q[1])                    low_cnt <= 9'd0;
         else if (low_cnt != BREAK_COUNT) low_cnt <= low_cnt + 9'd1;

         // Ack tracks the upcoming pulse while low and is frozen while high.
         if (!req_q[1]) ack <= ack_next;

         if (spi_clear_rx) rx_full <= 1'b0;

         if (req_rise) begin
            if (pulse_cnt != 8'hFE) pulse_cnt <= pulse_n;
            if (state == ST_IDLE) state <= ST_CMD;
            if (state != ST_OUTPUT_BITS) begin
               if (bits_left != 4'd0) begin
                  in_shift  <= {in_shift[6:0], 1'b0};
                  bits_left <= bits_left - 4'd1;
                  if (bits_left == 4'd1) tx_full <= 1'b0;
               end else if (pulse_n == PULSE_OUT_READY) begin
                  cmd_ok <= ack;
               end else if (check_pulse) begin
                  if (ack) begin
                     in_shift  <= tx_data;
                     bits_left <= BYTE_BITS;
                     state     <= ST_INPUT_SHIFT;
                  end else begin
                     state <= ST_CMD;
                  end
               end
            end
         end else if (group_end) begin
            pulse_cnt <= 8'd0;
            bits_left <= 4'd0;
            cmd_ok    <= 1'b0;
            if (pulse_cnt != 8'd0) begin
               case (state)
                  ST_CMD, ST_INPUT_SHIFT: begin
                     state   <= (pulse_cnt == PULSE_OUT_READY && cmd_ok) ? ST_OUTPUT_BITS : ST_IDLE;
                     out_idx <= 3'd0;
                  end
                  ST_OUTPUT_BITS: begin
                     if (pulse_cnt == 8'd1 || pulse_cnt == 8'd2) begin
                        out_shift <= {out_shift[5:0], group_bit};
                        out_idx   <= out_idx + 3'd1;
                        if (out_idx == 3'd7) begin
                           rx_data <= {out_shift, group_bit};
                           rx_full <= 1'b1;
                           state   <= ST_IDLE;
                        end
                     end else begin
                        state <= ST_IDLE;
                     end
                  end
                  default: state <= ST_IDLE;
               endcase
            end
         end

         if (spi_load_tx) begin
            tx_full <= 1'b1;
            tx_data <= spi_data;
         end
      end
   end

endmodule

// File: tb/tb_postbox_usb.sv
// Self-checking bench: plays the target (pulse groups) and the host (SPI frames)
// against a buffer-level model of the bridge, with directed and random traffic.
module tb_postbox_usb;
   import postbox_usb_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   postbox_usb_if bus ();

   postbox_usb dut (
      .fpga_clock_48mhz (clk),
      .reset_in         (rst),
      .bus              (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic       m_tx_full, m_rx_full;
   logic [7:0] m_tx, m_rx;
   bit         exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic play(input string tag);
      int  idx;
      logic got;
      idx = 1;
      while (exp_q.size() != 0) begin
         bus.testreq_3v = 1'b1;
         wait_clks(8);
         got = ~bus.testack_noe;
         bus.testreq_3v = 1'b0;
         check($sformatf("%s_ack%0d", tag, idx), 32'(got), 32'(exp_q.pop_front()));
         wait_clks(10);
         idx++;
      end
   endtask

   task automatic end_group();
      bus.testreq_3v = 1'b0;
      wait_clks(BREAK_CYCLES + 16);
   endtask

   // Pulse group from the start of a group: 3 = output-ready, 4 = input-ready, 5..12 = data.
   task automatic read_group(input int cnt, input string tag);
      for (int p = 1; p <= cnt; p++) begin
         if (p == 3)                exp_q.push_back(!m_rx_full);
         else if (p == 4)           exp_q.push_back(m_tx_full);
         else if (p >= 5 && p <= 12) exp_q.push_back(m_tx_full ? m_tx[12 - p] : 1'b0);
         else                       exp_q.push_back(1'b0);
      end
      play(tag);
      if (m_tx_full && cnt >= 12) m_tx_full = 1'b0;
   endtask

   // Continuation of a read group: one ready-check pulse then eight data pulses.
   task automatic chain_link(input int cnt, input string tag);
      for (int i = 0; i < cnt; i++) begin
         if (i == 0) exp_q.push_back(m_tx_full);
         else        exp_q.push_back(m_tx_full ? m_tx[8 - i] : 1'b0);
      end
      play(tag);
      if (m_tx_full && cnt >= 9) m_tx_full = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] data, input string tag);
      logic accepted;
      accepted = !m_rx_full;
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b0);
      exp_q.push_back(accepted);
      play({tag, "_cmd"});
      end_group();
      for (int i = 7; i >= 0; i--) begin
         exp_q.push_back(1'b0);
         if (data[i]) exp_q.push_back(1'b0);
         play($sformatf("%s_bit%0d", tag, i));
         end_group();
      end
      if (accepted) begin
         m_rx_full = 1'b1;
         m_rx      = data;
      end
   endtask

   task automatic spi(input logic has_byte, input logic has_space, input logic [7:0] data,
                      input string tag);
      logic [15:0] mo, mi;
      logic [7:0]  e0, e1;
      e0 = {6'b0, !m_tx_full, m_rx_full};
      e1 = m_rx_full ? m_rx : 8'h00;
      mo = {6'b0, has_byte, has_space, data};
      bus.fpga_spi_cs = 1'b0;
      wait_clks(6);
      for (int i = 15; i >= 0; i--) begin
         bus.fpga_spi_mosi = mo[i];
         wait_clks(6);
         mi[i] = bus.fpga_spi_miso;
         bus.fpga_spi_sck = 1'b1;
         wait_clks(6);
         bus.fpga_spi_sck = 1'b0;
      end
      wait_clks(4);
      bus.fpga_spi_cs = 1'b1;
      wait_clks(8);
      check({tag, "_status"}, 32'(mi[15:8]), 32'(e0));
      check({tag, "_data"}, 32'(mi[7:0]), 32'(e1));
      check({tag, "_miso_idle"}, 32'(bus.fpga_spi_miso), 32'd0);
      if (has_byte && !m_tx_full) begin
         m_tx_full = 1'b1;
         m_tx      = data;
      end
      if (has_space && m_rx_full) m_rx_full = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sz;
      string tag;
      rst                 = 1'b1;
      bus.fpga_spi_cs     = 1'b1;
      bus.fpga_spi_sck    = 1'b0;
      bus.fpga_spi_mosi   = 1'b0;
      bus.testreq_3v      = 1'b0;
      bus.target_power_3v = 1'b0;
      m_tx_full = 1'b0;
      m_rx_full = 1'b0;
      m_tx      = 8'h00;
      m_rx      = 8'h00;

      wait_clks(4);
      check("rst_ack_noe", 32'(bus.testack_noe), 32'd1);
      check("rst_miso", 32'(bus.fpga_spi_miso), 32'd0);
      check("rst_hotswap", 32'(bus.hotswap_noe), 32'd1);
      check("rst_target_reset", 32'(bus.target_reset_noe), 32'd1);
      rst = 1'b0;
      wait_clks(2);
      check("run_hotswap", 32'(bus.hotswap_noe), 32'd0);
      bus.target_power_3v = 1'b1;
      wait_clks(4);
      check("power_hi", 32'(bus.target_power_out), 32'd1);
      bus.target_power_3v = 1'b0;
      wait_clks(4);
      check("power_lo", 32'(bus.target_power_out), 32'd0);

      read_group(4, "empty4");
      end_group();
      spi(1'b0, 1'b1, 8'h00, "empty_spi");

      send_byte(8'hA8, "out_a8");
      read_group(3, "out_full");
      end_group();
      spi(1'b0, 1'b1, 8'h00, "out_read");
      spi(1'b0, 1'b1, 8'h00, "out_drained");

      spi(1'b1, 1'b1, 8'h5C, "load_first");
      spi(1'b1, 1'b1, 8'hE7, "load_reject");
      read_group(12, "read_5c");
      end_group();
      spi(1'b1, 1'b1, 8'h42, "load_42");
      read_group(12, "read_42");
      end_group();
      spi(1'b1, 1'b0, 8'hC3, "load_c3");
      read_group(12, "read_c3");
      end_group();

      spi(1'b1, 1'b0, 8'h12, "chain_12");
      read_group(12, "chain_rd12");
      spi(1'b1, 1'b0, 8'hFF, "chain_ff");
      chain_link(9, "chain_rdff");
      spi(1'b1, 1'b0, 8'h34, "chain_34");
      chain_link(9, "chain_rd34");
      chain_link(1, "chain_stop");
      end_group();

      spi(1'b1, 1'b0, 8'h5A, "rst_load");
      send_byte(8'h3C, "rst_out");
      read_group(6, "rst_part");
      bus.testreq_3v = 1'b1;
      rst = 1'b1;
      wait_clks(3);
      check("midrst_ack_noe", 32'(bus.testack_noe), 32'd1);
      check("midrst_miso", 32'(bus.fpga_spi_miso), 32'd0);
      check("midrst_hotswap", 32'(bus.hotswap_noe), 32'd1);
      bus.testreq_3v = 1'b0;
      rst = 1'b0;
      m_tx_full = 1'b0;
      m_rx_full = 1'b0;
      wait_clks(2);
      check("postrst_hotswap", 32'(bus.hotswap_noe), 32'd0);
      end_group();
      spi(1'b0, 1'b0, 8'h00, "postrst_spi");
      read_group(4, "postrst_grp");
      end_group();

      for (int it = 0; it < 24; it++) begin
         tag = $sformatf("rnd%0d", it);
         case ($urandom_range(0, 4))
            0: spi(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), tag);
            1: begin
               sz = int'($urandom_range(1, 12));
               if (sz >= 3) sz++;
               read_group(sz, tag);
               end_group();
            end
            2: begin
               if ($urandom_range(0, 2) == 0) send_byte(8'($urandom), tag);
               else                           spi(1'b0, 1'b1, 8'h00, tag);
            end
            3: begin
               spi(1'b1, 1'b0, 8'($urandom), tag);
               read_group(12, tag);
               end_group();
            end
            default: spi(1'b0, 1'b1, 8'h00, tag);
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
